// File: rtl/cursor_ctrl.sv
// cursor_ctrl: owns cursor position, size and enable for the video-out
// overlay stage. The host writes shadow registers; an optional auto-bounce
// engine moves the cursor by itself. Shadow values reach the active outputs
// only on a rising edge of in_vsync, so the overlay never tears mid-frame.
//
// Ports:
//   vo_clk, vo_reset_   video clock, async active-low reset
//   in_vsync            vsync level from the timing generator
//   reg_wr/reg_rd       request, held high until reg_ack
//   reg_addr            0=CTRL{[1]auto,[0]en} 1=X 2=Y 3=SIZE{[15:8]h,[7:0]w}
//   reg_wdata           write data
//   reg_ack/reg_rdata   one-cycle ack, shadow read data valid with ack
//   cur_en/x/y/w/h      active cursor values for the overlay
//   frame_tick          pulse on the cycle the active values update
//
// state  | meaning
// IDLE   | nothing pending; vsync commits only when auto mode is on
// DIRTY  | a host write is waiting for the next vsync edge
// COMMIT | one cycle copying shadow (or bounced position) to active
module cursor_ctrl #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 1024,
  parameter int DEF_SIZE = 50,
  parameter int STEP     = 1
) (
  input  logic        vo_clk,
  input  logic        vo_reset_,
  input  logic        in_vsync,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic        reg_ack,
  output logic [31:0] reg_rdata,
  output logic        cur_en,
  output logic [11:0] cur_x,
  output logic [10:0] cur_y,
  output logic [7:0]  cur_w,
  output logic [7:0]  cur_h,
  output logic        frame_tick
);

  typedef enum logic [1:0] {IDLE, DIRTY, COMMIT} state_t;

  localparam logic [12:0] H_LIM  = 13'(H_ACTIVE);
  localparam logic [11:0] V_LIM  = 12'(V_ACTIVE);
  localparam logic [11:0] STEP_X = 12'(STEP);
  localparam logic [10:0] STEP_Y = 11'(STEP);
  localparam logic [7:0]  DEF_SZ = 8'(DEF_SIZE);

  state_t      state;
  logic        vs_q;
  logic        sh_en, sh_auto, act_auto;
  logic [11:0] sh_x;
  logic [10:0] sh_y;
  logic [7:0]  sh_w, sh_h;
  logic        x_wr, y_wr;
  logic        dir_x, dir_y;

  logic        vs_edge, req_ok, wr_ok, rd_ok;
  logic [12:0] x_sum, x_fwd;
  logic [11:0] y_sum, y_fwd;
  logic [11:0] x_wr_val, nx;
  logic [10:0] y_wr_val, ny;
  logic        ndx, ndy;
  logic [31:0] rd_val;
  logic        unused_wdata;

  // Only the low 16 bits carry register fields.
  assign unused_wdata = ^reg_wdata[31:16];

  assign vs_edge = in_vsync & ~vs_q;
  // reg_ack high blocks re-acceptance of the request that is still held.
  assign req_ok  = (reg_wr | reg_rd) & ~reg_ack & (state != COMMIT);
  assign wr_ok   = req_ok & reg_wr;
  assign rd_ok   = req_ok & ~reg_wr;

  // Write clamping keeps the cursor fully on screen for the shadow size.
  assign x_sum    = {1'b0, reg_wdata[11:0]} + {5'd0, sh_w};
  assign y_sum    = {1'b0, reg_wdata[10:0]} + {4'd0, sh_h};
  assign x_wr_val = (x_sum > H_LIM) ? 12'(H_LIM - {5'd0, sh_w}) : reg_wdata[11:0];
  assign y_wr_val = (y_sum > V_LIM) ? 11'(V_LIM - {4'd0, sh_h}) : reg_wdata[10:0];

  // Bounce step from the on-screen position, using the size being committed.
  assign x_fwd = {1'b0, cur_x} + {5'd0, sh_w} + 13'(STEP);
  assign y_fwd = {1'b0, cur_y} + {4'd0, sh_h} + 12'(STEP);

  always_comb begin
    nx  = cur_x;
    ndx = dir_x;
    if (!dir_x) begin
      if (x_fwd <= H_LIM) nx = cur_x + STEP_X;
      else begin
        nx  = 12'(H_LIM - {5'd0, sh_w});
        ndx = 1'b1;
      end
    end else begin
      if (cur_x >= STEP_X) nx = cur_x - STEP_X;
      else begin
        nx  = '0;
        ndx = 1'b0;
      end
    end
  end

  always_comb begin
    ny  = cur_y;
    ndy = dir_y;
    if (!dir_y) begin
      if (y_fwd <= V_LIM) ny = cur_y + STEP_Y;
      else begin
        ny  = 11'(V_LIM - {4'd0, sh_h});
        ndy = 1'b1;
      end
    end else begin
      if (cur_y >= STEP_Y) ny = cur_y - STEP_Y;
      else begin
        ny  = '0;
        ndy = 1'b0;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_addr)
      2'd0: rd_val = {30'd0, sh_auto, sh_en};
      2'd1: rd_val = {20'd0, sh_x};
      2'd2: rd_val = {21'd0, sh_y};
      2'd3: rd_val = {16'd0, sh_h, sh_w};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge vo_clk or negedge vo_reset_) begin
    if (!vo_reset_) begin
      state      <= IDLE;
      vs_q       <= 1'b0;
      sh_en      <= 1'b0;
      sh_auto    <= 1'b0;
      sh_x       <= '0;
      sh_y       <= '0;
      sh_w       <= DEF_SZ;
      sh_h       <= DEF_SZ;
      x_wr       <= 1'b0;
      y_wr       <= 1'b0;
      dir_x      <= 1'b0;
      dir_y      <= 1'b0;
      act_auto   <= 1'b0;
      cur_en     <= 1'b0;
      cur_x      <= '0;
      cur_y      <= '0;
      cur_w      <= DEF_SZ;
      cur_h      <= DEF_SZ;
      reg_ack    <= 1'b0;
      reg_rdata  <= '0;
      frame_tick <= 1'b0;
    end else begin
      vs_q       <= in_vsync;
      reg_ack    <= req_ok;
      reg_rdata  <= rd_ok ? rd_val : '0;
      frame_tick <= (state == COMMIT);

      if (wr_ok) begin
        case (reg_addr)
          2'd0: begin
            sh_en   <= reg_wdata[0];
            sh_auto <= reg_wdata[1];
          end
          2'd1: begin
            sh_x <= x_wr_val;
            x_wr <= 1'b1;
          end
          2'd2: begin
            sh_y <= y_wr_val;
            y_wr <= 1'b1;
          end
          default: begin
            sh_w <= (reg_wdata[7:0] == 8'd0) ? 8'd1 : reg_wdata[7:0];
            sh_h <= (reg_wdata[15:8] == 8'd0) ? 8'd1 : reg_wdata[15:8];
          end
        endcase
      end

      case (state)
        IDLE: begin
          // A write accepted on the edge cycle still makes this frame.
          if (vs_edge && (sh_auto || act_auto || wr_ok)) state <= COMMIT;
          else if (wr_ok) state <= DIRTY;
        end
        DIRTY: begin
          if (vs_edge) state <= COMMIT;
        end
        COMMIT: begin
          cur_en   <= sh_en;
          act_auto <= sh_auto;
          cur_w    <= sh_w;
          cur_h    <= sh_h;
          // A host-written axis takes the shadow value even in auto mode.
          if (!sh_auto || x_wr) cur_x <= sh_x;
          else begin
            cur_x <= nx;
            sh_x  <= nx;
            dir_x <= ndx;
          end
          if (!sh_auto || y_wr) cur_y <= sh_y;
          else begin
            cur_y <= ny;
            sh_y  <= ny;
            dir_y <= ndy;
          end
          x_wr  <= 1'b0;
          y_wr  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_ctrl.sv
module tb_cursor_ctrl;
  localparam int H = 1280;
  localparam int V = 1024;
  localparam int DEF = 50;
  localparam int STEP = 1;

  logic        vo_clk = 1'b0;
  logic        vo_reset_;
  logic        in_vsync;
  logic        reg_wr, reg_rd;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_ack;
  logic [31:0] reg_rdata;
  logic        cur_en;
  logic [11:0] cur_x;
  logic [10:0] cur_y;
  logic [7:0]  cur_w, cur_h;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail = 0;

  always #5 vo_clk = ~vo_clk;

  cursor_ctrl dut (
    .vo_clk(vo_clk), .vo_reset_(vo_reset_), .in_vsync(in_vsync),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata),
    .cur_en(cur_en), .cur_x(cur_x), .cur_y(cur_y), .cur_w(cur_w), .cur_h(cur_h),
    .frame_tick(frame_tick)
  );

  // reference model: shadow (m_*), active (a_*), bounce directions, pending flags
  int m_en, m_auto, m_x, m_y, m_w, m_h;
  int a_en, a_auto, a_x, a_y, a_w, a_h;
  int dir_x, dir_y;
  bit m_pend, m_xw, m_yw;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_x = 0; m_y = 0; m_w = DEF; m_h = DEF;
    a_en = 0; a_auto = 0; a_x = 0; a_y = 0; a_w = DEF; a_h = DEF;
    dir_x = 0; dir_y = 0;
    m_pend = 0; m_xw = 0; m_yw = 0;
  endtask

  task automatic model_write(input int addr, input logic [31:0] d);
    int v;
    m_pend = 1;
    case (addr)
      0: begin m_en = int'(d[0]); m_auto = int'(d[1]); end
      1: begin
        v = int'(d[11:0]);
        if (v + m_w > H) v = H - m_w;
        m_x = v; m_xw = 1;
      end
      2: begin
        v = int'(d[10:0]);
        if (v + m_h > V) v = V - m_h;
        m_y = v; m_yw = 1;
      end
      default: begin
        m_w = (d[7:0] == 8'd0) ? 1 : int'(d[7:0]);
        m_h = (d[15:8] == 8'd0) ? 1 : int'(d[15:8]);
      end
    endcase
  endtask

  function automatic int model_rd(input int addr);
    case (addr)
      0: return m_auto * 2 + m_en;
      1: return m_x;
      2: return m_y;
      default: return m_h * 256 + m_w;
    endcase
  endfunction

  function automatic void bounce(input int pos, input int size, input int limit,
                                 inout int dir, output int npos);
    if (dir == 0) begin
      if (pos + size + STEP <= limit) npos = pos + STEP;
      else begin npos = limit - size; dir = 1; end
    end else begin
      if (pos >= STEP) npos = pos - STEP;
      else begin npos = 0; dir = 0; end
    end
  endfunction

  task automatic model_frame(output bit c);
    int np;
    c = m_pend || (m_auto != 0) || (a_auto != 0);
    if (c) begin
      a_en = m_en; a_auto = m_auto; a_w = m_w; a_h = m_h;
      if (m_auto != 0 && !m_xw) begin bounce(a_x, m_w, H, dir_x, np); a_x = np; m_x = np; end
      else a_x = m_x;
      if (m_auto != 0 && !m_yw) begin bounce(a_y, m_h, V, dir_y, np); a_y = np; m_y = np; end
      else a_y = m_y;
      m_pend = 0; m_xw = 0; m_yw = 0;
    end
  endtask

  // All tasks start and end just after a rising clock edge.
  task automatic wr_reg(input int addr, input logic [31:0] data);
    bit acked = 0;
    reg_addr = 2'(addr); reg_wdata = data; reg_wr = 1'b1;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(posedge vo_clk); #1;
      if (reg_ack) acked = 1;
    end
    reg_wr = 1'b0;
    chk("wr_ack", int'(acked), 1);
    if (acked) model_write(addr, data);
  endtask

  task automatic rd_reg(input int addr, output logic [31:0] d);
    bit acked = 0;
    d = '0;
    reg_addr = 2'(addr); reg_rd = 1'b1;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(posedge vo_clk); #1;
      if (reg_ack) begin acked = 1; d = reg_rdata; end
    end
    reg_rd = 1'b0;
    chk("rd_ack", int'(acked), 1);
  endtask

  task automatic chk_active(input string tag);
    chk({tag, "_en"}, int'(cur_en), a_en);
    chk({tag, "_x"}, int'(cur_x), a_x);
    chk({tag, "_y"}, int'(cur_y), a_y);
    chk({tag, "_w"}, int'(cur_w), a_w);
    chk({tag, "_h"}, int'(cur_h), a_h);
  endtask

  task automatic do_frame(input int hold);
    int o_x, o_en, ticks;
    bit c;
    o_x = a_x; o_en = a_en;
    model_frame(c);
    in_vsync = 1'b1;
    @(posedge vo_clk); @(negedge vo_clk);
    chk("tick_pre", int'(frame_tick), 0);
    chk("x_pre", int'(cur_x), o_x);
    chk("en_pre", int'(cur_en), o_en);
    @(negedge vo_clk);
    chk("tick_commit", int'(frame_tick), int'(c));
    chk_active("commit");
    ticks = int'(frame_tick);
    for (int k = 0; k <= hold + 2; k++) begin
      @(negedge vo_clk);
      ticks += int'(frame_tick);
      if (k == hold) in_vsync = 1'b0;
    end
    chk("tick_count", ticks, int'(c));
    @(posedge vo_clk); #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int exp_x[4] = '{1230, 1230, 1229, 1228};
    int prev_y;
    bit c;

    vo_reset_ = 1'b0; in_vsync = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0;
    reg_addr = '0; reg_wdata = '0;
    model_reset();
    repeat (3) @(posedge vo_clk);
    #1;
    chk_active("reset");
    chk("reset_tick", int'(frame_tick), 0);
    chk("reset_ack", int'(reg_ack), 0);
    chk("reset_rdata", int'(reg_rdata), 0);
    vo_reset_ = 1'b1;
    @(posedge vo_clk); #1;

    // idle edges are ignored
    repeat (3) do_frame(3);
    chk("idle_x", int'(cur_x), 0);
    chk("idle_w", int'(cur_w), 50);
    chk("idle_en", int'(cur_en), 0);

    // basic host commit
    wr_reg(1, 100); wr_reg(2, 200); wr_reg(0, 1);
    do_frame(2);
    chk("basic_x", int'(cur_x), 100);
    chk("basic_y", int'(cur_y), 200);
    chk("basic_en", int'(cur_en), 1);

    // right-edge clamp
    wr_reg(1, 1270);
    rd_reg(1, d);
    chk("clamp_rd", int'(d), 1230);
    chk("clamp_rd_model", int'(d), model_rd(1));
    do_frame(1);
    chk("clamp_x", int'(cur_x), 1230);

    // auto bounce at the right edge
    wr_reg(0, 3); wr_reg(1, 1229);
    do_frame(1);
    chk("auto_start_x", int'(cur_x), 1229);
    for (int i = 0; i < 4; i++) begin
      prev_y = int'(cur_y);
      do_frame(1);
      chk("auto_x", int'(cur_x), exp_x[i]);
      chk("auto_y", int'(cur_y), prev_y + 1);
    end
    rd_reg(2, d);
    chk("auto_y_rd", int'(d), model_rd(2));

    // write held across the COMMIT cycle is stalled one cycle
    wr_reg(0, 1); wr_reg(1, 300);
    model_frame(c);
    in_vsync = 1'b1;
    @(posedge vo_clk); #1;
    reg_addr = 2'd1; reg_wdata = 32'd400; reg_wr = 1'b1;
    @(negedge vo_clk);
    chk("stall_tick_pre", int'(frame_tick), 0);
    @(posedge vo_clk); #1;
    chk("stall_ack_commit", int'(reg_ack), 0);
    chk("stall_tick", int'(frame_tick), 1);
    chk("stall_x", int'(cur_x), 300);
    @(posedge vo_clk); #1;
    chk("stall_ack", int'(reg_ack), 1);
    reg_wr = 1'b0;
    if (reg_ack) model_write(1, 32'd400);
    in_vsync = 1'b0;
    repeat (3) @(posedge vo_clk);
    #1;
    do_frame(1);
    chk("stall_landed_x", int'(cur_x), 400);

    // reset asserted during COMMIT
    wr_reg(1, 500);
    in_vsync = 1'b1;
    @(posedge vo_clk); @(negedge vo_clk);
    vo_reset_ = 1'b0;
    #1;
    model_reset();
    chk_active("rst_commit");
    chk("rst_commit_tick", int'(frame_tick), 0);
    @(posedge vo_clk); #1;
    vo_reset_ = 1'b1; in_vsync = 1'b0;
    repeat (2) @(posedge vo_clk);
    #1;
    do_frame(2);
    chk("rst_after_x", int'(cur_x), 0);

    // randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      int nops = $urandom_range(0, 3);
      for (int j = 0; j < nops; j++) begin
        int addr = $urandom_range(0, 3);
        logic [31:0] wd;
        if ($urandom_range(0, 2) == 0) begin
          rd_reg(addr, d);
          chk("rand_rd", int'(d), model_rd(addr));
        end else begin
          case (addr)
            0: wd = {$urandom} & 32'hFFFF_FFF3 | 32'($urandom_range(0, 3));
            1: wd = ({$urandom} & 32'hFFFF_F000) | 32'($urandom_range(0, 1400));
            2: wd = ({$urandom} & 32'hFFFF_F800) | 32'($urandom_range(0, 1100));
            default: begin
              wd = $urandom;
              if ($urandom_range(0, 5) == 0) wd[7:0] = 8'd0;
              if ($urandom_range(0, 5) == 0) wd[15:8] = 8'd0;
            end
          endcase
          wr_reg(addr, wd);
        end
      end
      do_frame($urandom_range(1, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cursor_ctrl.md
Name: cursor_ctrl

Overview:
- Owns cursor position, size and enable for the video-out cursor overlay stage.
- A host register port writes shadow registers, or an internal auto-bounce engine moves the cursor.
- Shadow values are committed to the active outputs only at a frame boundary (rising edge of in_vsync), so the overlay never tears mid-frame.
- Sits in the vo_clk domain beside the overlay stage and drives its x/y/w/h/enable inputs.

Parameters:
- H_ACTIVE, 1280: active pixels per line; horizontal clamp limit.
- V_ACTIVE, 1024: active lines per frame; vertical clamp limit.
- DEF_SIZE, 50: reset width and height of the cursor.
- STEP, 1: pixels moved per frame in auto mode.

Ports:
- vo_clk  in  1  video clock.
- vo_reset_  in  1  asynchronous, active-low reset.
- in_vsync  in  1  vsync level from the video timing generator.
- reg_wr  in  1  write request; held high until acked.
- reg_rd  in  1  read request; held high until acked.
- reg_addr  in  2  0=CTRL{[0]en,[1]auto}, 1=X[11:0], 2=Y[10:0], 3=SIZE{[7:0]w,[15:8]h}.
- reg_wdata  in  32  write data.
- reg_ack  out  1  one-cycle acknowledge for a read or a write.
- reg_rdata  out  32  shadow register value; valid while reg_ack is high.
- cur_en  out  1  active cursor enable.
- cur_x  out  12  active cursor left edge.
- cur_y  out  11  active cursor top edge.
- cur_w  out  8  active width.
- cur_h  out  8  active height.
- frame_tick  out  1  one-cycle pulse on the cycle the active outputs update.

Behaviour:
- Reset (asynchronous, vo_reset_=0):
  - Shadow and active: en=0, auto=0, x=0, y=0, w=h=DEF_SIZE.
  - Bounce direction bits = 0 (moving right and down).
  - reg_ack=0, reg_rdata=0, frame_tick=0.
  - State = IDLE.
  - Reset asserted mid-commit aborts the commit and returns everything to reset values.
- Vsync edge detect: vs_q registers in_vsync; edge = in_vsync & ~vs_q. A vsync held high for many cycles produces one commit only.
- FSM states: IDLE, DIRTY, COMMIT.
  - IDLE -> DIRTY on an accepted write.
  - IDLE -> COMMIT on edge when auto=1 (shadow or committed active).
  - DIRTY -> COMMIT on edge.
  - COMMIT -> IDLE after exactly one cycle.
  - Without auto and without a pending write, an edge is ignored: no COMMIT, no frame_tick.
- Register handshake:
  - A request is accepted when reg_wr|reg_rd is high, reg_ack was 0 in the previous cycle, and the state is not COMMIT.
  - reg_ack pulses for one cycle, the cycle after acceptance.
  - reg_wr and reg_rd both high: the write wins; reg_rdata is undefined.
  - Requests arriving during COMMIT are stalled one cycle; none are dropped.
- Write clamping (into shadow):
  - X: if wdata+w > H_ACTIVE, store H_ACTIVE-w.
  - Y: if wdata+h > V_ACTIVE, store V_ACTIVE-h.
  - SIZE: a zero width or height is stored as 1.
  - Unused bits are ignored on write and read back as 0.
- X/Y-written flags: set by writes to X or Y, cleared in COMMIT.
- COMMIT cycle:
  - active <= shadow for en, auto, w, h.
  - Position with auto=0 or a pending X/Y write: active <= shadow x/y.
  - Position otherwise: active <= bounce step of the current active x/y.
- Bounce, per axis, with separate x and y direction bits:
  - Moving forward: if pos+size+STEP <= limit then pos += STEP; else pos = limit-size and flip direction.
  - Moving backward: if pos >= STEP then pos -= STEP; else pos = 0 and flip direction.
  - The shadow x/y tracks the bounced value so reads reflect the position on screen.
- Latency:
  - in_vsync first sampled high in cycle N -> COMMIT state in N+1 -> outputs and frame_tick updated in N+2.
  - A write acked in or before cycle N+1 lands in that frame's commit.

Test Plan:
- Reset release, no writes, 3 vsync edges -> no frame_tick; cur_x=0, cur_w=50, cur_en=0.
- Write X=100, Y=200, CTRL=1, then vsync -> outputs unchanged before the edge; cur_x=100, cur_y=200, cur_en=1 at N+2 with a single frame_tick.
- Write X=1270 with w=50 -> reads back 1230; after vsync, cur_x=1230.
- CTRL=3 (auto), start x=1229, STEP=1 -> successive frames give cur_x=1230, 1230 (direction flips), 1229, 1228; y increments each frame.
- reg_wr held high across the COMMIT cycle -> ack delayed exactly one cycle, write lands in the next frame.
- Assert vo_reset_ in the COMMIT cycle -> all outputs return to reset values asynchronously; the next edge after release is ignored.
